adj_list_server: RTL and testbench
==================================

# adj_list_server

Graph-adjacency responder serving the traversal core's successor-read port. The host streams edges in during a load phase. The block then answers each `rd_next_node_reg` pulse from `digital_top` with one successor node index and a remaining-successor count on `next_node_idx` / `next_node_counter`. It sits beside `digital_top` and holds the same graph the cocotb bench currently models in software.

## Interface
Parameters:
- `PARAM_NODE_IDX_WIDTH`, default 10: node index width; node table depth is 2^W.
- `PARAM_COUNTER_WIDTH`, default 5: successor-count width; maximum out-degree is 2^W−1.
- `PARAM_EDGE_ADDR_WIDTH`, default 11: edge memory address width; 2048 edges.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear_req` in 1: pulse; wipes the graph and re-enters CLEAR.
- `load_valid` in 1: edge present on `load_src` / `load_dst`.
- `load_ready` out 1: edge accepted when `load_valid & load_ready`.
- `load_src` in NODE_IDX: edge source.
- `load_dst` in NODE_IDX: edge destination.
- `load_done` in 1: pulse; ends the load phase.
- `table_ready` out 1: high in READY only.
- `load_err` out 1: sticky error flag, cleared only by reset or `clear_req`.
- `node_idx_reg` in NODE_IDX: node being expanded; sampled with rd.
- `rd_next_node_reg` in 1: one-cycle read request.
- `next_node_idx` out NODE_IDX: successor returned.
- `next_node_counter` out COUNTER: successors remaining, including the one returned.

## Operation
- FSM states: CLEAR → LOAD → READY.
- Reset enters CLEAR. `clear_req` in any state also enters CLEAR.
- CLEAR:
  - sweeps `clr_ptr` from 0 to 2^NODE_IDX−1, zeroing `count[]` and `seen[]`, one entry per cycle;
  - moves to LOAD after the last entry.
- LOAD:
  - `load_ready`=1; one edge accepted per cycle.
  - Edges must arrive grouped by source.
  - When `load_src` ≠ `last_src` or this is the first edge: if `seen[src]` is set, raise `load_err` and drop the edge. Otherwise set `seen[src]`, set `base[src]`=`wr_ptr`, set `count[src]`=1.
  - Same source as the previous edge: `count[src]`++.
  - Every stored edge writes `edge_mem[wr_ptr]`=`dst` and increments `wr_ptr`.
  - Overflow: an edge arriving when `count` is already at its maximum, or when `wr_ptr` is 2^EDGE_ADDR, raises `load_err` and drops the edge. No wrap of `wr_ptr`.
  - `load_done` moves to READY. `load_done` with `load_valid` in the same cycle stores the edge first.
- READY:
  - `rd_next_node_reg` at cycle t samples `node_idx_reg`.
  - If the node differs from `cur_node`, or `cursor`=0, start at the first successor: `cursor`=0, `cur_node`=node.
  - Response appears at t+1.
  - `count`=0 → `next_node_idx`=0, `next_node_counter`=0.
  - Otherwise → `next_node_idx`=`edge_mem[base+cursor]`, `next_node_counter`=`count−cursor`, then `cursor`++.
  - When `cursor` reaches `count`, it wraps to 0 so the next read of the same node restarts the list.
- Outputs hold their value between reads.
- `rd_next_node_reg` outside READY is ignored; outputs stay 0.
- `load_valid` outside LOAD is ignored and is not an error.

## Timing
- Reset values: `load_ready`=0, `table_ready`=0, `load_err`=0, `next_node_idx`=0, `next_node_counter`=0; `cursor`, `wr_ptr`, `cur_node`=0.
- CLEAR lasts exactly 2^NODE_IDX cycles (1024 at defaults). `load_ready` rises the cycle after the sweep finishes.
- Read latency is 1 cycle, fully registered. Back-to-back rd pulses every cycle are supported.
- `clear_req` has priority over rd, load and `load_done`:
  - outputs go to 0 on the next edge;
  - an in-flight response is discarded.
- Reset mid-operation: all state returns to CLEAR. Memory contents are don't-care because `seen` and `count` are re-cleared.

## Configuration
- `ADJ_SERVER_STATS_EN` defined:
  - adds output `rd_count` (32 bits), which counts serviced READY reads;
  - adds output `max_degree` (COUNTER width), the largest count loaded;
  - both are reset and zeroed by `clear_req`.
- Macro undefined: neither port exists and no counters are built.

## Structure
- Package `adj_pkg` holds:
  - width localparams;
  - the state enum (CLEAR, LOAD, READY);
  - the `edge_addr_t`, `node_idx_t` and `counter_t` typedefs.
- Sub-module `adj_edge_ram`: synchronous single-port RAM (write in LOAD, read in READY), 1-cycle read latency.
- The `base` and `count` tables are register arrays inside the top.

## Test plan
- Reset, wait 1024 cycles → `load_ready`=1 exactly at cycle 1024 after reset release; outputs 0 throughout.
- Load edges 5→7, 5→9, 5→3, 2→8, then `load_done`. Read node 5 three times → (7,3), (9,2), (3,1). A fourth read → (7,3) again.
- Interleaved reads: read node 5 once → (7,3); then read node 2 → (8,1); then read node 5 → (7,3), because the node change restarts the list.
- Read node 12, which has no edges → (0,0). Read with `table_ready`=0 → outputs stay 0.
- Load 5→1, 6→2, 5→4 → `load_err`=1; edge 5→4 is dropped; reading 5 → (1,1). Load 32 edges from one source → `load_err`=1 and `count` stays 31.
- `clear_req` while in READY → `table_ready`=0 next cycle, a 1024-cycle CLEAR follows, then reload succeeds with `load_err`=0. With `ADJ_SERVER_STATS_EN`, `rd_count` matches the number of reads and returns to 0.

Source files
------------

// File: rtl/adj_pkg.sv
// Shared widths, state encoding and index types for the adjacency-list server.
package adj_pkg;

  localparam int NODE_IDX_W  = 10;
  localparam int COUNTER_W   = 5;
  localparam int EDGE_ADDR_W = 11;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  typedef logic [EDGE_ADDR_W-1:0] edge_addr_t;
  typedef logic [NODE_IDX_W-1:0]  node_idx_t;
  typedef logic [COUNTER_W-1:0]   counter_t;

endpackage

// File: rtl/adj_edge_ram.sv
// Single-port edge store: writes during load, registered read (1 cycle) during serving.
module adj_edge_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // rdata only moves on a read, so the last response holds between reads
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/adj_list_server.sv
// Graph adjacency responder: CLEAR sweep, grouped edge load, then per-node successor reads.
// Optional statistics outputs are built when ADJ_SERVER_STATS_EN is defined.
module adj_list_server
  import adj_pkg::*;
#(
  parameter int PARAM_NODE_IDX_WIDTH  = NODE_IDX_W,
  parameter int PARAM_COUNTER_WIDTH   = COUNTER_W,
  parameter int PARAM_EDGE_ADDR_WIDTH = EDGE_ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear_req,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] load_src,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] load_dst,
  input  logic                            load_done,
  output logic                            table_ready,
  output logic                            load_err,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] node_idx_reg,
  input  logic                            rd_next_node_reg,
  output logic [PARAM_NODE_IDX_WIDTH-1:0] next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]  next_node_counter
`ifdef ADJ_SERVER_STATS_EN
  ,
  output logic [31:0]                     rd_count,
  output logic [PARAM_COUNTER_WIDTH-1:0]  max_degree
`endif
);

  localparam int NW      = PARAM_NODE_IDX_WIDTH;
  localparam int CW      = PARAM_COUNTER_WIDTH;
  localparam int EW      = PARAM_EDGE_ADDR_WIDTH;
  localparam int N_NODES = 1 << NW;

  state_t          state;
  logic [NW-1:0]   clr_ptr;
  logic [EW:0]     wr_ptr;
  logic            have_last;
  logic [NW-1:0]   last_src;
  logic [CW-1:0]   cursor;
  logic [NW-1:0]   cur_node;
  logic            vld_p1;

  logic [CW-1:0]   count_tbl [N_NODES];
  logic [EW-1:0]   base_tbl  [N_NODES];
  logic [N_NODES-1:0] seen_tbl;

  logic            ld_fire, ld_store, ld_err, new_src, mem_full;
  logic [CW-1:0]   src_cnt, new_cnt;
  logic            rd_fire, rd_restart, rd_wrap;
  logic [CW-1:0]   rd_cnt, eff_cursor, cursor_inc;
  logic [EW-1:0]   rd_addr, ram_addr;
  logic [NW-1:0]   ram_rdata;

  assign load_ready  = (state == LOAD);
  assign table_ready = (state == READY);

  always_comb begin
    ld_fire  = (state == LOAD) && load_valid && !clear_req;
    new_src  = !have_last || (load_src != last_src);
    src_cnt  = count_tbl[load_src];
    mem_full = wr_ptr[EW];
    new_cnt  = new_src ? CW'(1) : src_cnt + 1'b1;
    ld_store = 1'b0;
    ld_err   = 1'b0;
    if (ld_fire) begin
      if (new_src && seen_tbl[load_src]) begin
        ld_err = 1'b1;
      end else if (mem_full || (!new_src && (src_cnt == {CW{1'b1}}))) begin
        ld_err = 1'b1;
      end else begin
        ld_store = 1'b1;
      end
    end
  end

  always_comb begin
    rd_fire    = (state == READY) && rd_next_node_reg && !clear_req;
    rd_cnt     = count_tbl[node_idx_reg];
    rd_restart = (node_idx_reg != cur_node) || (cursor == '0);
    eff_cursor = rd_restart ? '0 : cursor;
    cursor_inc = eff_cursor + 1'b1;
    rd_wrap    = (cursor_inc == rd_cnt);
    rd_addr    = base_tbl[node_idx_reg] + EW'(eff_cursor);
    ram_addr   = (state == LOAD) ? wr_ptr[EW-1:0] : rd_addr;
  end

  // Tables are wiped by the CLEAR sweep rather than by reset
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      seen_tbl[clr_ptr]  <= 1'b0;
      count_tbl[clr_ptr] <= '0;
    end else if (ld_store) begin
      count_tbl[load_src] <= new_cnt;
      if (new_src) begin
        seen_tbl[load_src] <= 1'b1;
        base_tbl[load_src] <= wr_ptr[EW-1:0];
      end
    end
  end

  adj_edge_ram #(
    .ADDR_W (EW),
    .DATA_W (NW)
  ) u_edge_ram (
    .clk   (clk),
    .we    (ld_store),
    .re    (rd_fire && (rd_cnt != '0)),
    .addr  (ram_addr),
    .wdata (load_dst),
    .rdata (ram_rdata)
  );

  assign next_node_idx = vld_p1 ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= CLEAR;
      clr_ptr           <= '0;
      wr_ptr            <= '0;
      have_last         <= 1'b0;
      last_src          <= '0;
      load_err          <= 1'b0;
      cursor            <= '0;
      cur_node          <= '0;
      vld_p1            <= 1'b0;
      next_node_counter <= '0;
    end else if (clear_req) begin
      state             <= CLEAR;
      clr_ptr           <= '0;
      wr_ptr            <= '0;
      have_last         <= 1'b0;
      last_src          <= '0;
      load_err          <= 1'b0;
      cursor            <= '0;
      cur_node          <= '0;
      vld_p1            <= 1'b0;
      next_node_counter <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == '1) state <= LOAD;
        end
        LOAD: begin
          if (ld_err) load_err <= 1'b1;
          if (ld_store) begin
            wr_ptr    <= wr_ptr + 1'b1;
            have_last <= 1'b1;
            last_src  <= load_src;
          end
          if (load_done) state <= READY;
        end
        READY: begin
          // Read stage p0 -> p1: response registered, cursor advanced or wrapped
          if (rd_fire) begin
            cur_node <= node_idx_reg;
            if (rd_cnt == '0) begin
              vld_p1            <= 1'b0;
              next_node_counter <= '0;
              cursor            <= '0;
            end else begin
              vld_p1            <= 1'b1;
              next_node_counter <= rd_cnt - eff_cursor;
              cursor            <= rd_wrap ? '0 : cursor_inc;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef ADJ_SERVER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count   <= '0;
      max_degree <= '0;
    end else if (clear_req) begin
      rd_count   <= '0;
      max_degree <= '0;
    end else begin
      if (rd_fire) rd_count <= rd_count + 32'd1;
      if (ld_store && (new_cnt > max_degree)) max_degree <= new_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_adj_list_server.sv
// Self-checking bench for adj_list_server: table-driven reads with a response scoreboard.
module tb_adj_list_server;
  import adj_pkg::*;

  localparam int NW = 10;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_req;
  logic          load_valid;
  logic          load_ready;
  logic [NW-1:0] load_src;
  logic [NW-1:0] load_dst;
  logic          load_done;
  logic          table_ready;
  logic          load_err;
  logic [NW-1:0] node_idx_reg;
  logic          rd_next_node_reg;
  logic [NW-1:0] next_node_idx;
  logic [CW-1:0] next_node_counter;
`ifdef ADJ_SERVER_STATS_EN
  logic [31:0]   rd_count;
  logic [CW-1:0] max_degree;
`endif

  always #5 clk = ~clk;

  adj_list_server dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clear_req         (clear_req),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_src          (load_src),
    .load_dst          (load_dst),
    .load_done         (load_done),
    .table_ready       (table_ready),
    .load_err          (load_err),
    .node_idx_reg      (node_idx_reg),
    .rd_next_node_reg  (rd_next_node_reg),
    .next_node_idx     (next_node_idx),
    .next_node_counter (next_node_counter)
`ifdef ADJ_SERVER_STATS_EN
    ,
    .rd_count          (rd_count),
    .max_degree        (max_degree)
`endif
  );

  typedef struct {
    int node;
    int idx;
    int cnt;
  } vec_t;

  typedef struct {
    int idx;
    int cnt;
  } resp_t;

  int    errors = 0;
  int    checks = 0;
  int    n_reads = 0;
  resp_t sb[$];
  vec_t  vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_pop(input string name);
    resp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got response expected none (scoreboard empty)", name);
    end else begin
      e = sb.pop_front();
      check({name, "_idx"}, int'(next_node_idx), e.idx);
      check({name, "_cnt"}, int'(next_node_counter), e.cnt);
    end
  endtask

  task automatic read_chk(input string name, input int node, input int eidx, input int ecnt);
    resp_t e;
    @(negedge clk);
    node_idx_reg     = NW'(node);
    rd_next_node_reg = 1'b1;
    e.idx = eidx;
    e.cnt = ecnt;
    sb.push_back(e);
    n_reads++;
    @(negedge clk);
    rd_next_node_reg = 1'b0;
    compare_pop(name);
  endtask

  task automatic load_edge(input int src, input int dst, input bit done);
    @(negedge clk);
    load_valid = 1'b1;
    load_src   = NW'(src);
    load_dst   = NW'(dst);
    load_done  = done;
    @(negedge clk);
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic finish_load();
    @(negedge clk);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
  endtask

  // Counts edges from the start of a clear until load_ready rises; the outputs must stay quiet.
  task automatic wait_clear(input string name, input bit poke_rd);
    int k;
    bit bad;
    bad = 1'b0;
    for (k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (next_node_idx != '0 || next_node_counter != '0 || table_ready) bad = 1'b1;
      if (load_ready) break;
      if (poke_rd && k == 500) begin
        node_idx_reg     = NW'(5);
        rd_next_node_reg = 1'b1;
      end
      if (k == 501) rd_next_node_reg = 1'b0;
    end
    rd_next_node_reg = 1'b0;
    check({name, "_len"}, k, 1024);
    check({name, "_quiet"}, int'(bad), 0);
  endtask

  task automatic do_clear(input string name, input bit with_rd);
    @(negedge clk);
    clear_req = 1'b1;
    if (with_rd) begin
      node_idx_reg     = NW'(5);
      rd_next_node_reg = 1'b1;
    end
    @(negedge clk);
    clear_req        = 1'b0;
    rd_next_node_reg = 1'b0;
    check({name, "_tready"}, int'(table_ready), 0);
    check({name, "_idx0"}, int'(next_node_idx), 0);
    check({name, "_cnt0"}, int'(next_node_counter), 0);
    check({name, "_err0"}, int'(load_err), 0);
    n_reads = 0;
`ifdef ADJ_SERVER_STATS_EN
    check({name, "_rdcount0"}, int'(rd_count), 0);
`endif
    wait_clear(name, 1'b0);
  endtask

  initial begin
    vecs[0] = '{5, 7, 3};
    vecs[1] = '{5, 9, 2};
    vecs[2] = '{5, 3, 1};
    vecs[3] = '{5, 7, 3};
    vecs[4] = '{2, 8, 1};
    vecs[5] = '{5, 7, 3};
    vecs[6] = '{12, 0, 0};
    vecs[7] = '{2, 8, 1};
    vecs[8] = '{5, 7, 3};
    vecs[9] = '{5, 9, 2};

    rst_n = 1'b0;
    clear_req = 1'b0;
    load_valid = 1'b0;
    load_src = '0;
    load_dst = '0;
    load_done = 1'b0;
    node_idx_reg = '0;
    rd_next_node_reg = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_load_ready", int'(load_ready), 0);
    check("rst_table_ready", int'(table_ready), 0);
    check("rst_load_err", int'(load_err), 0);
    check("rst_idx", int'(next_node_idx), 0);
    check("rst_cnt", int'(next_node_counter), 0);
    rst_n = 1'b1;
    wait_clear("init_clear", 1'b1);

    load_edge(5, 7, 1'b0);
    load_edge(5, 9, 1'b0);
    load_edge(5, 3, 1'b0);
    load_edge(2, 8, 1'b1);
    check("load1_tready", int'(table_ready), 1);
    check("load1_err", int'(load_err), 0);
    check("load1_lready", int'(load_ready), 0);

    // Back-to-back reads: response for vector i is compared while vector i+1 is driven
    for (int i = 0; i < 10; i++) begin
      resp_t e;
      @(negedge clk);
      if (i > 0) compare_pop($sformatf("vec%0d", i - 1));
      node_idx_reg     = NW'(vecs[i].node);
      rd_next_node_reg = 1'b1;
      e.idx = vecs[i].idx;
      e.cnt = vecs[i].cnt;
      sb.push_back(e);
      n_reads++;
    end
    @(negedge clk);
    rd_next_node_reg = 1'b0;
    compare_pop("vec9");

    load_edge(5, 0, 1'b0);
    check("ready_load_ignored_err", int'(load_err), 0);
    check("hold_idx", int'(next_node_idx), 9);
    check("hold_cnt", int'(next_node_counter), 2);
`ifdef ADJ_SERVER_STATS_EN
    check("rd_count", int'(rd_count), n_reads);
    check("max_degree1", int'(max_degree), 3);
`endif

    do_clear("clear1", 1'b1);
    load_edge(5, 1, 1'b0);
    load_edge(6, 2, 1'b0);
    check("regroup_err_before", int'(load_err), 0);
    load_edge(5, 4, 1'b0);
    check("regroup_err", int'(load_err), 1);
    finish_load();
    check("load2_tready", int'(table_ready), 1);
    read_chk("regroup_rd5", 5, 1, 1);
    read_chk("regroup_rd6", 6, 2, 1);

    do_clear("clear2", 1'b0);
    for (int i = 0; i < 31; i++) load_edge(9, 100 + i, 1'b0);
    check("deg31_err", int'(load_err), 0);
    load_edge(9, 200, 1'b0);
    check("deg_ovf_err", int'(load_err), 1);
    finish_load();
    read_chk("deg_rd0", 9, 100, 31);
    read_chk("deg_rd1", 9, 101, 30);
`ifdef ADJ_SERVER_STATS_EN
    check("max_degree31", int'(max_degree), 31);
`endif

    do_clear("clear3", 1'b0);
    load_edge(5, 7, 1'b0);
    load_edge(5, 8, 1'b1);
    check("reload_err", int'(load_err), 0);
    read_chk("reload_rd0", 5, 7, 2);
    read_chk("reload_rd1", 5, 8, 1);
    read_chk("reload_rd2", 5, 7, 2);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tready", int'(table_ready), 0);
    check("midrst_lready", int'(load_ready), 0);
    check("midrst_idx", int'(next_node_idx), 0);
    check("midrst_cnt", int'(next_node_counter), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
